// File: rtl/adder_share_arbiter_pkg.sv
// Shared FSM encoding and sizing defaults for the adder_share_arbiter slice.
package adder_share_arbiter_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DATA_W  = 32;

  // Smallest requester-index width that satisfies 2**ID_W >= NUM_REQ.
  function automatic int id_w_for(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction
endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester-side bus of the shared adder: request handshake, response strobe and tag.
// rsp_ovf_o exists only when ADDER_SHARE_ARBITER_OVF_EN is defined.
interface adder_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_src1_i;
  logic [NUM_REQ*DATA_W-1:0] req_src2_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_sum_o;
  logic [ID_W-1:0]           rsp_id_o;
  logic                      busy_o;
`ifdef ADDER_SHARE_ARBITER_OVF_EN
  logic                      rsp_ovf_o;
`endif

  modport master (
    output req_valid_i, req_src1_i, req_src2_i,
`ifdef ADDER_SHARE_ARBITER_OVF_EN
    input  rsp_ovf_o,
`endif
    input  req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_src1_i, req_src2_i,
`ifdef ADDER_SHARE_ARBITER_OVF_EN
    output rsp_ovf_o,
`endif
    output req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o, busy_o
  );
endinterface

// File: rtl/adder_share_arbiter_adder.sv
// The shared datapath adder; sum wraps modulo 2**DATA_W, carry-out discarded.
module adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/adder_share_arbiter_rr.sv
// Combinational round-robin grant: first valid at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  localparam int JW = ID_W + 1;

  logic [JW-1:0] j;

  // Scan from the farthest offset down so the nearest valid to ptr is written last and wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + JW'(i);
      if (j >= JW'(NUM_REQ)) j = j - JW'(NUM_REQ);
      if (valid[j[ID_W-1:0]]) begin
        grant                = '0;
        grant[j[ID_W-1:0]]   = 1'b1;
        idx                  = j[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one adder among NUM_REQ requesters; 2-cycle latency, one request per 2 cycles,
// no response backpressure. ADDER_SHARE_ARBITER_OVF_EN adds a registered signed-overflow flag.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ID_W    = id_w_for(NUM_REQ)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  adder_share_arbiter_if.slave bus
);
  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, id_q, rsp_id_q, grant_idx;
  logic [NUM_REQ-1:0] grant, ready, rsp_vld_q;
  logic [DATA_W-1:0]  src1_q, src2_q, sum_c, sum_q;
  logic               hs;
  logic [DATA_W-1:0]  src1_arr [NUM_REQ];
  logic [DATA_W-1:0]  src2_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign src1_arr[k] = bus.req_src1_i[k*DATA_W +: DATA_W];
    assign src2_arr[k] = bus.req_src2_i[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .valid (bus.req_valid_i),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  adder #(.DATA_W(DATA_W)) u_adder (
    .a   (src1_q),
    .b   (src2_q),
    .sum (sum_c)
  );

  // Ready is gated by reset so no grant is visible while the block is held in reset.
  always_comb begin
    state_d = state_q;
    ready   = '0;
    case (state_q)
      ST_IDLE: begin
        ready = rst_i ? grant : '0;
        if (|(bus.req_valid_i & ready)) state_d = ST_CALC;
      end
      ST_CALC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign hs = (state_q == ST_IDLE) && |(bus.req_valid_i & ready);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      sum_q     <= '0;
      rsp_id_q  <= '0;
      rsp_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= '0;
      if (hs) begin
        src1_q <= src1_arr[grant_idx];
        src2_q <= src2_arr[grant_idx];
        id_q   <= grant_idx;
        ptr_q  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state_q == ST_CALC) begin
        sum_q     <= sum_c;
        rsp_id_q  <= id_q;
        rsp_vld_q <= NUM_REQ'(1) << id_q;
      end
    end
  end

`ifdef ADDER_SHARE_ARBITER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == ST_CALC) begin
      ovf_q <= (src1_q[DATA_W-1] == src2_q[DATA_W-1]) &&
               (sum_c[DATA_W-1] != src1_q[DATA_W-1]);
    end
  end

  assign bus.rsp_ovf_o = ovf_q;
`endif

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = rsp_vld_q;
  assign bus.rsp_sum_o   = sum_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.busy_o      = (state_q == ST_CALC);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: reset, latency, wrap/overflow, fairness, pointer, withdraw, mid-op reset.
module tb_adder_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid_i[k] = 1'b1;
    bus.req_src1_i[k*DATA_W +: DATA_W] = a;
    bus.req_src2_i[k*DATA_W +: DATA_W] = b;
  endtask

  task automatic idle_all();
    bus.req_valid_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 32'h5, 32'h6);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready_o); end
    n_checks++; if (bus.rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_sum_o !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", bus.rsp_sum_o); end
    n_checks++; if (bus.rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.rsp_id_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
`ifdef ADDER_SHARE_ARBITER_OVF_EN
    n_checks++; if (bus.rsp_ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.rsp_ovf_o); end
`endif
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive(0, 32'h0000_0004, 32'h0040_0000);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", bus.req_ready_o); end
    @(posedge clk);
    @(negedge clk);
    // Scribble the operands after the handshake; the latched copy must be used.
    idle_all();
    drive(0, 32'hDEAD_BEEF, 32'h1234_5678);
    bus.req_valid_i[0] = 1'b0;
    #1;
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy_o); end
    n_checks++; if (bus.rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL single_early_rsp: got %b want 0000", bus.rsp_valid_o); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0001", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_sum_o !== 32'h0040_0004) begin n_fail++; $display("FAIL single_sum: got %h want 00400004", bus.rsp_sum_o); end
    n_checks++; if (bus.rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", bus.rsp_id_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", bus.busy_o); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_width: got %b want 0000", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_sum_o !== 32'h0040_0004) begin n_fail++; $display("FAIL single_sum_hold: got %h want 00400004", bus.rsp_sum_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] a   [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] b   [2] = '{32'h0000_0001, 32'h0000_0001};
    logic [31:0] exp [2] = '{32'h0000_0000, 32'h8000_0000};
    logic        ovf [2] = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      drive(2, a[t], b[t]);
      #1;
      n_checks++; if (bus.req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL wrap_grant[%0d]: got %b want 0100", t, bus.req_ready_o); end
      @(posedge clk);
      @(negedge clk);
      idle_all();
      @(negedge clk); #1;
      n_checks++; if (bus.rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL wrap_rsp_valid[%0d]: got %b want 0100", t, bus.rsp_valid_o); end
      n_checks++; if (bus.rsp_sum_o !== exp[t]) begin n_fail++; $display("FAIL wrap_sum[%0d]: got %h want %h", t, bus.rsp_sum_o, exp[t]); end
      n_checks++; if (bus.rsp_id_o !== 2'd2) begin n_fail++; $display("FAIL wrap_id[%0d]: got %0d want 2", t, bus.rsp_id_o); end
`ifdef ADDER_SHARE_ARBITER_OVF_EN
      n_checks++; if (bus.rsp_ovf_o !== ovf[t]) begin n_fail++; $display("FAIL wrap_ovf[%0d]: got %b want %b", t, bus.rsp_ovf_o, ovf[t]); end
`else
      if (ovf[t] === 1'bx) $display("unexpected ovf table entry");
`endif
    end
  endtask

  // Pointer enters at 3 (last grant was requester 2).
  task automatic test_pointer_hold();
    @(negedge clk);
    drive(1, 32'h0000_1000, 32'h0000_0234);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL ptr_grant1: got %b want 0010", bus.req_ready_o); end
    @(posedge clk); @(negedge clk); idle_all();
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_id_o !== 2'd1 || bus.rsp_sum_o !== 32'h0000_1234) begin n_fail++; $display("FAIL ptr_rsp1: got id %0d sum %h want id 1 sum 00001234", bus.rsp_id_o, bus.rsp_sum_o); end
    repeat (3) @(negedge clk);
    drive(3, 32'h0000_0003, 32'h0000_0030);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL ptr_grant3: got %b want 1000", bus.req_ready_o); end
    @(posedge clk); @(negedge clk); idle_all();
    @(negedge clk);
    drive(0, 32'h0000_0100, 32'h0000_0001);
    drive(1, 32'h0000_0200, 32'h0000_0002);
    #1;
    n_checks++; if (bus.rsp_valid_o !== 4'b1000 || bus.rsp_sum_o !== 32'h0000_0033) begin n_fail++; $display("FAIL ptr_rsp3: got valid %b sum %h want 1000 00000033", bus.rsp_valid_o, bus.rsp_sum_o); end
    n_checks++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL ptr_grant0: got %b want 0001", bus.req_ready_o); end
    @(posedge clk); @(negedge clk); idle_all();
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_id_o !== 2'd0 || bus.rsp_sum_o !== 32'h0000_0101) begin n_fail++; $display("FAIL ptr_rsp0: got id %0d sum %h want id 0 sum 00000101", bus.rsp_id_o, bus.rsp_sum_o); end
  endtask

  // Pointer enters at 1.
  task automatic test_withdraw();
    @(negedge clk);
    drive(3, 32'h0000_0500, 32'h0000_0005);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL wd_grant3: got %b want 1000", bus.req_ready_o); end
    @(posedge clk); @(negedge clk);
    idle_all();
    drive(2, 32'h0000_0777, 32'h0000_0001);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL wd_ready_calc: got %b want 0000", bus.req_ready_o); end
    @(negedge clk);
    idle_all();
    #1;
    n_checks++; if (bus.rsp_valid_o !== 4'b1000) begin n_fail++; $display("FAIL wd_rsp3: got %b want 1000", bus.rsp_valid_o); end
    n_checks++; if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL wd_no_grant: got %b want 0000", bus.req_ready_o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.rsp_valid_o !== 4'b0000 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL wd_quiet[%0d]: got valid %b busy %b want 0000 0", c, bus.rsp_valid_o, bus.busy_o); end
    end
    @(negedge clk);
    drive(2, 32'h0000_0010, 32'h0000_0002);
    drive(3, 32'h0000_0020, 32'h0000_0003);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL wd_ptr_kept: got %b want 0100", bus.req_ready_o); end
    @(posedge clk); @(negedge clk); idle_all();
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_id_o !== 2'd2 || bus.rsp_sum_o !== 32'h0000_0012) begin n_fail++; $display("FAIL wd_rsp2: got id %0d sum %h want id 2 sum 00000012", bus.rsp_id_o, bus.rsp_sum_o); end
  endtask

  // Pointer enters at 3; a grant to 1 would move it to 2 if reset failed to clear it.
  task automatic test_reset_mid();
    @(negedge clk);
    drive(1, 32'h0000_0abc, 32'h0000_0001);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL rm_grant1: got %b want 0010", bus.req_ready_o); end
    @(posedge clk); @(negedge clk);
    idle_all();
    drive(3, 32'h0000_0001, 32'h0000_0001);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", bus.busy_o); end
    n_checks++; if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rm_ready: got %b want 0000", bus.req_ready_o); end
    n_checks++; if (bus.rsp_sum_o !== 32'h0 || bus.rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL rm_outputs: got sum %h id %0d want 0 0", bus.rsp_sum_o, bus.rsp_id_o); end
    @(negedge clk);
    idle_all();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (bus.rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL rm_no_pulse[%0d]: got %b want 0000", c, bus.rsp_valid_o); end
      @(negedge clk);
    end
    drive(0, 32'h0000_0040, 32'h0000_0004);
    drive(3, 32'h0000_0300, 32'h0000_0003);
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rm_grant_from0: got %b want 0001", bus.req_ready_o); end
    @(posedge clk); @(negedge clk); idle_all();
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid_o !== 4'b0001 || bus.rsp_sum_o !== 32'h0000_0044) begin n_fail++; $display("FAIL rm_rsp0: got valid %b sum %h want 0001 00000044", bus.rsp_valid_o, bus.rsp_sum_o); end
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_gnt;
    logic [31:0] exp_sum;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) drive(k, 32'((k + 1) * 16), 32'(k));
    #1;
    for (int n = 0; n < 8; n++) begin
      exp_gnt = 4'b0001 << (n % 4);
      exp_sum = 32'(((n % 4) + 1) * 16 + (n % 4));
      n_checks++; if (bus.req_ready_o !== exp_gnt) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", n, bus.req_ready_o, exp_gnt); end
      @(posedge clk); @(negedge clk); #1;
      n_checks++; if (bus.busy_o !== 1'b1 || bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL fair_calc[%0d]: got busy %b ready %b want 1 0000", n, bus.busy_o, bus.req_ready_o); end
      @(posedge clk); @(negedge clk);
      if (n == 7) idle_all();
      #1;
      n_checks++; if (bus.rsp_valid_o !== exp_gnt || bus.rsp_id_o !== 2'(n % 4) || bus.rsp_sum_o !== exp_sum) begin
        n_fail++; $display("FAIL fair_rsp[%0d]: got valid %b id %0d sum %h want %b %0d %h", n, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_sum_o, exp_gnt, n % 4, exp_sum);
      end
    end
    @(negedge clk); #1;
    n_checks++; if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL fair_drain: got busy %b ready %b want 0 0000", bus.busy_o, bus.req_ready_o); end
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_src1_i  = '0;
    bus.req_src2_i  = '0;
    test_reset();
    test_single();
    test_wrap();
    test_pointer_hold();
    test_withdraw();
    test_reset_mid();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
